// File: rtl/spi_reg_bank_if.sv
// SPI pin and register-bank output bundle for spi_reg_bank.
// slave faces the peripheral; master faces the driving controller or bench.
interface spi_reg_bank_if #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
);
  logic                         nCS;
  logic                         SCLK;
  logic                         COPI;
  logic                         cipo;
  logic                         cipo_oe;
  logic [NUM_REGS*DATA_W-1:0]   regs_flat;
  logic                         wr_strobe;
  logic [ADDR_W-1:0]            wr_addr;

  modport slave (
    input  nCS, SCLK, COPI,
    output cipo, cipo_oe, regs_flat, wr_strobe, wr_addr
  );

  modport master (
    output nCS, SCLK, COPI,
    input  cipo, cipo_oe, regs_flat, wr_strobe, wr_addr
  );
endinterface

// File: rtl/spi_reg_bank.sv
// SPI mode-0 register bank: R/W + address + data frames, CIPO read-back,
// and a one-clock write strobe when a well-formed in-range write commits.
module spi_reg_bank #(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_reg_bank_if.slave    bus
);

  localparam int unsigned F      = 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W  = $clog2(F + 2);
  localparam int unsigned REGS_W = NUM_REGS * DATA_W;

  localparam logic [CNT_W-1:0] CNT_ADDR_END = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME    = CNT_W'(F);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(F + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [F-1:0]        sin_q, sin_d;
  logic [DATA_W-1:0]   sout_q, sout_d;
  logic                cipo_q, cipo_d;
  logic                cipo_oe_q, cipo_oe_d;
  logic [REGS_W-1:0]   regs_q, regs_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;

  logic [1:0] ncs_sync_q, sclk_sync_q, copi_sync_q;
  logic       ncs_prev_q, sclk_prev_q;

  // Two-flop synchronisers plus previous-value flops for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_sync_q  <= 2'b11;
      sclk_sync_q <= 2'b00;
      copi_sync_q <= 2'b00;
      ncs_prev_q  <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      ncs_sync_q  <= {ncs_sync_q[0],  bus.nCS};
      sclk_sync_q <= {sclk_sync_q[0], bus.SCLK};
      copi_sync_q <= {copi_sync_q[0], bus.COPI};
      ncs_prev_q  <= ncs_sync_q[1];
      sclk_prev_q <= sclk_sync_q[1];
    end
  end

  logic ncs_fall, ncs_rise, sclk_rise, sclk_fall, copi_s;
  assign ncs_fall  = ~ncs_sync_q[1] &  ncs_prev_q;
  assign ncs_rise  =  ncs_sync_q[1] & ~ncs_prev_q;
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_prev_q;
  assign copi_s    =  copi_sync_q[1];

  logic [F-1:0]      sin_shift;
  logic [ADDR_W-1:0] rd_addr, cm_addr;
  logic [DATA_W-1:0] rd_data, cm_data;
  logic              cm_hit;

  // Read mux and write-address decode; out-of-range addresses match no register
  always_comb begin
    sin_shift = {sin_q[F-2:0], copi_s};
    rd_addr   = sin_shift[ADDR_W-1:0];
    cm_addr   = sin_q[F-2 -: ADDR_W];
    cm_data   = sin_q[DATA_W-1:0];
    rd_data   = '0;
    cm_hit    = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i*DATA_W +: DATA_W];
      if (cm_addr == ADDR_W'(i)) cm_hit  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sin_q       <= '0;
      sout_q      <= '0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sin_q       <= sin_d;
      sout_q      <= sout_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sin_d       = sin_q;
    sout_d      = sout_q;
    cipo_d      = cipo_q;
    cipo_oe_d   = cipo_oe_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;

    unique case (state_q)
      IDLE: begin
        cipo_d = 1'b0;
        if (ncs_fall) begin
          state_d   = SHIFT;
          cnt_d     = '0;
          sin_d     = '0;
          sout_d    = '0;
          cipo_oe_d = 1'b1;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = COMMIT;
        end else if (sclk_rise) begin
          sin_d = sin_shift;
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
          // Address just completed on this edge: preload read data
          if (cnt_q == CNT_W'(ADDR_W) && !sin_shift[ADDR_W]) sout_d = rd_data;
        end else if (sclk_fall) begin
          if (cnt_q >= CNT_ADDR_END && cnt_q < CNT_FRAME) begin
            cipo_d = sout_q[DATA_W-1];
            sout_d = {sout_q[DATA_W-2:0], 1'b0};
          end else begin
            cipo_d = 1'b0;
          end
        end
      end
      COMMIT: begin
        state_d   = IDLE;
        cipo_d    = 1'b0;
        cipo_oe_d = 1'b0;
        if (cnt_q == CNT_FRAME && sin_q[F-1] && cm_hit) begin
          for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (cm_addr == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = cm_data;
          end
          wr_strobe_d = 1'b1;
          wr_addr_d   = cm_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cipo      = cipo_q;
  assign bus.cipo_oe   = cipo_oe_q;
  assign bus.regs_flat = regs_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: SCLK at clk/8, hand-computed frames and results.
module tb_spi_reg_bank;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   strobes;

  spi_reg_bank_if ifc ();

  spi_reg_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && ifc.wr_strobe) strobes++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCLK period: data set with SCLK low, cipo/cipo_oe sampled just before the rise
  task automatic bit_cycle(input logic b, output logic c, output logic oe);
    ifc.COPI = b;
    wait_clks(4);
    c  = ifc.cipo;
    oe = ifc.cipo_oe;
    ifc.SCLK = 1'b1;
    wait_clks(4);
    ifc.SCLK = 1'b0;
  endtask

  task automatic xfer(input int nbits, input logic [31:0] frame,
                      output logic [7:0] rd, output logic oe_all);
    logic c, oe;
    rd     = 8'h00;
    oe_all = 1'b1;
    ifc.nCS = 1'b0;
    wait_clks(6);
    for (int k = 0; k < nbits; k++) begin
      bit_cycle(frame[nbits-1-k], c, oe);
      oe_all = oe_all & oe;
      if (k >= 8 && k < 16) rd = {rd[6:0], c};
    end
    wait_clks(4);
    ifc.nCS = 1'b1;
    wait_clks(18);
  endtask

  initial begin
    logic [7:0]  rd;
    logic        oe_all;
    logic        c, oe;
    logic [31:0] frame;
    int          s0;

    total   = 0;
    bad     = 0;
    strobes = 0;
    rst_n   = 1'b0;
    ifc.nCS  = 1'b1;
    ifc.SCLK = 1'b0;
    ifc.COPI = 1'b0;

    wait_clks(5);
    check("rst_regs", 64'(ifc.regs_flat), 64'h0);
    check("rst_oe", 64'(ifc.cipo_oe), 64'h0);
    check("rst_strobe", 64'(ifc.wr_strobe), 64'h0);
    check("rst_cipo", 64'(ifc.cipo), 64'h0);
    rst_n = 1'b1;
    wait_clks(5);
    check("post_rst_regs", 64'(ifc.regs_flat), 64'h0);

    // Write 0xA5 to addr 3
    s0 = strobes;
    xfer(16, 32'h83A5, rd, oe_all);
    check("wr3_regs", 64'(ifc.regs_flat), 64'h00000000_A5000000);
    check("wr3_strobes", 64'(strobes - s0), 64'd1);
    check("wr3_addr", 64'(ifc.wr_addr), 64'd3);
    check("wr3_oe_during", 64'(oe_all), 64'd1);
    check("wr3_oe_after", 64'(ifc.cipo_oe), 64'd0);

    // Write 0x3C to addr 5, then read it back
    s0 = strobes;
    xfer(16, 32'h853C, rd, oe_all);
    check("wr5_regs", 64'(ifc.regs_flat), 64'h00003C00_A5000000);
    check("wr5_addr", 64'(ifc.wr_addr), 64'd5);
    xfer(16, 32'h0500, rd, oe_all);
    check("rd5_data", 64'(rd), 64'h3C);
    check("rd5_oe_during", 64'(oe_all), 64'd1);
    check("rd5_oe_after", 64'(ifc.cipo_oe), 64'd0);
    check("rd5_regs", 64'(ifc.regs_flat), 64'h00003C00_A5000000);
    check("rd5_strobes", 64'(strobes - s0), 64'd1);

    xfer(16, 32'h0300, rd, oe_all);
    check("rd3_data", 64'(rd), 64'hA5);

    // Out-of-range address
    s0 = strobes;
    xfer(16, 32'h88FF, rd, oe_all);
    check("wr8_strobes", 64'(strobes - s0), 64'd0);
    check("wr8_regs", 64'(ifc.regs_flat), 64'h00003C00_A5000000);
    check("wr8_addr", 64'(ifc.wr_addr), 64'd5);
    xfer(16, 32'h0800, rd, oe_all);
    check("rd8_data", 64'(rd), 64'h00);

    // Short and long frames to addr 0
    s0 = strobes;
    xfer(15, 32'h4055, rd, oe_all);
    xfer(17, 32'h100AB, rd, oe_all);
    check("badlen_regs", 64'(ifc.regs_flat), 64'h00003C00_A5000000);
    check("badlen_strobes", 64'(strobes - s0), 64'd0);

    // Back-to-back writes
    s0 = strobes;
    xfer(16, 32'h8011, rd, oe_all);
    xfer(16, 32'h8122, rd, oe_all);
    check("b2b_regs", 64'(ifc.regs_flat), 64'h00003C00_A5002211);
    check("b2b_strobes", 64'(strobes - s0), 64'd2);
    check("b2b_addr", 64'(ifc.wr_addr), 64'd1);

    // Reset mid-frame, then finish the frame: must not commit
    frame = 32'h8277;
    ifc.nCS = 1'b0;
    wait_clks(6);
    for (int k = 0; k < 5; k++) bit_cycle(frame[15-k], c, oe);
    check("mid_oe_before_rst", 64'(ifc.cipo_oe), 64'd1);
    rst_n = 1'b0;
    wait_clks(3);
    check("mid_rst_regs", 64'(ifc.regs_flat), 64'h0);
    check("mid_rst_oe", 64'(ifc.cipo_oe), 64'd0);
    check("mid_rst_addr", 64'(ifc.wr_addr), 64'd0);
    rst_n = 1'b1;
    s0 = strobes;
    for (int k = 5; k < 16; k++) bit_cycle(frame[15-k], c, oe);
    wait_clks(4);
    ifc.nCS = 1'b1;
    wait_clks(18);
    check("mid_after_regs", 64'(ifc.regs_flat), 64'h0);
    check("mid_after_strobes", 64'(strobes - s0), 64'd0);
    check("mid_after_oe", 64'(ifc.cipo_oe), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
